// File: rtl/tilt_move_gen.sv
// Converts signed accelerometer tilt into rate-controlled, one-hot movement pulses for Ball.
// Pulse period shrinks with tilt level and is always spaced by at least MIN_GAP cycles.
module tilt_move_gen #(
    parameter int unsigned ACCEL_WIDTH = 12,
    parameter int unsigned DEAD_ZONE   = 64,
    parameter int unsigned TILT_SHIFT  = 7,
    parameter int unsigned BASE_PERIOD = 1000000,
    parameter int unsigned MIN_GAP     = 64,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          accel_valid,
    input  logic signed [ACCEL_WIDTH-1:0] accel_x,
    input  logic signed [ACCEL_WIDTH-1:0] accel_y,
    output logic        [3:0]             movement,
    output logic        [3:0]             tilt_dir,
    output logic        [1:0]             tilt_level
);

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [ACCEL_WIDTH-1:0] MAG_MAX  = {1'b0, {(ACCEL_WIDTH-1){1'b1}}};
    localparam logic [ACCEL_WIDTH-1:0] DZ       = ACCEL_WIDTH'(DEAD_ZONE);
    localparam logic [CNT_WIDTH-1:0]   BASE_CNT = CNT_WIDTH'(BASE_PERIOD);
    localparam logic [CNT_WIDTH-1:0]   GAP_CNT  = CNT_WIDTH'(MIN_GAP);
    localparam logic [CNT_WIDTH-1:0]   ONE_CNT  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StFirst, StRun} state_e;

    state_e                          state_q, state_d;
    logic signed [ACCEL_WIDTH-1:0]   x_q, y_q;
    logic        [3:0]               tilt_dir_q, tilt_dir_d;
    logic        [1:0]               tilt_level_q, tilt_level_d;
    logic        [3:0]               movement_q, movement_d;
    logic        [3:0]               run_dir_q, run_dir_d;
    logic        [CNT_WIDTH-1:0]     step_q, step_d;
    logic        [CNT_WIDTH-1:0]     gap_q, gap_d;

    logic        [ACCEL_WIDTH-1:0]   mag_x, mag_y;
    logic                            act_x, act_y;
    logic        [CNT_WIDTH-1:0]     period_raw, period;
    logic                            step_due, gap_ok, pulse;

    // Most-negative sample has no positive twin; clamp it to the largest magnitude.
    function automatic logic [ACCEL_WIDTH-1:0] abs_sat(input logic signed [ACCEL_WIDTH-1:0] v);
        if (v[ACCEL_WIDTH-1] && (v[ACCEL_WIDTH-2:0] == '0)) begin
            return MAG_MAX;
        end else if (v[ACCEL_WIDTH-1]) begin
            return $unsigned(-v);
        end else begin
            return $unsigned(v);
        end
    endfunction

    function automatic logic [1:0] level_of(input logic [ACCEL_WIDTH-1:0] mag);
        logic [ACCEL_WIDTH-1:0] excess;
        excess = (mag - DZ - 1'b1) >> TILT_SHIFT;
        return (excess[ACCEL_WIDTH-1:2] != '0) ? 2'd3 : excess[1:0];
    endfunction

    // Sample capture and registered decode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q          <= '0;
            y_q          <= '0;
            tilt_dir_q   <= '0;
            tilt_level_q <= '0;
        end else begin
            if (accel_valid) begin
                x_q <= accel_x;
                y_q <= accel_y;
            end
            tilt_dir_q   <= tilt_dir_d;
            tilt_level_q <= tilt_level_d;
        end
    end

    always_comb begin
        mag_x        = abs_sat(x_q);
        mag_y        = abs_sat(y_q);
        act_x        = mag_x > DZ;
        act_y        = mag_y > DZ;
        tilt_dir_d   = '0;
        tilt_level_d = '0;
        if (act_x && (!act_y || (mag_x >= mag_y))) begin
            tilt_dir_d   = x_q[ACCEL_WIDTH-1] ? DIR_LEFT : DIR_RIGHT;
            tilt_level_d = level_of(mag_x);
        end else if (act_y) begin
            tilt_dir_d   = y_q[ACCEL_WIDTH-1] ? DIR_UP : DIR_DOWN;
            tilt_level_d = level_of(mag_y);
        end
    end

    // Pacing: the gap test counts the registering edge itself, so a pulse may land exactly
    // MIN_GAP edges after the previous one.
    always_comb begin
        period_raw = BASE_CNT >> tilt_level_q;
        period     = (period_raw < GAP_CNT) ? GAP_CNT : period_raw;
        step_due   = step_q >= (period - ONE_CNT);
        gap_ok     = gap_q >= (GAP_CNT - ONE_CNT);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (tilt_dir_q != '0) state_d = StFirst;
                end
                StFirst: begin
                    if (tilt_dir_q == '0) begin
                        state_d = StIdle;
                    end else if (gap_ok) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (tilt_dir_q == '0) begin
                        state_d = StIdle;
                    end else if (tilt_dir_q != run_dir_q) begin
                        state_d = StFirst;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs and counters
    always_comb begin
        pulse     = 1'b0;
        step_d    = step_q;
        run_dir_d = run_dir_q;
        case (state_q)
            StIdle: begin
                step_d = '0;
            end
            StFirst: begin
                step_d = '0;
                if (enable && (tilt_dir_q != '0) && gap_ok) begin
                    pulse     = 1'b1;
                    run_dir_d = tilt_dir_q;
                end
            end
            StRun: begin
                if (enable && (tilt_dir_q != '0) && (tilt_dir_q == run_dir_q)) begin
                    if (step_due && gap_ok) begin
                        pulse  = 1'b1;
                        step_d = '0;
                    end else begin
                        step_d = step_q + ONE_CNT;
                    end
                end else begin
                    step_d = '0;
                end
            end
            default: step_d = '0;
        endcase
        movement_d = pulse ? tilt_dir_q : 4'b0000;
        if (pulse) begin
            gap_d = '0;
        end else if (gap_q >= GAP_CNT) begin
            gap_d = gap_q;
        end else begin
            gap_d = gap_q + ONE_CNT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            movement_q <= '0;
            run_dir_q  <= '0;
            step_q     <= '0;
            gap_q      <= GAP_CNT;
        end else begin
            movement_q <= movement_d;
            run_dir_q  <= run_dir_d;
            step_q     <= step_d;
            gap_q      <= gap_d;
        end
    end

    assign movement   = movement_q;
    assign tilt_dir   = tilt_dir_q;
    assign tilt_level = tilt_level_q;

`ifndef SYNTHESIS
    movement_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(movement_q));
    movement_single : assert property (@(posedge clk) disable iff (!reset)
        (movement_q != '0) |=> (movement_q == '0));
`endif

endmodule

// File: tb/tb_tilt_move_gen.sv
// Directed bench for tilt_move_gen: decode table plus multi-cycle pacing, enable and reset
// sequences. A second instance with a short base period exercises MIN_GAP clamping.
module tb_tilt_move_gen;

    localparam int AW = 12;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 enable = 1'b0;
    logic                 accel_valid = 1'b0;
    logic signed [AW-1:0] accel_x = '0;
    logic signed [AW-1:0] accel_y = '0;
    logic [3:0]           movement, tilt_dir, fast_movement, fast_dir;
    logic [1:0]           tilt_level, fast_level;

    int n_cmp = 0;
    int n_fail = 0;
    int mon_bad = 0;
    logic [3:0] prev_m = '0;
    logic [3:0] prev_f = '0;

    typedef struct {
        int x;
        int y;
        int dir;
        int lvl;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    tilt_move_gen #(
        .ACCEL_WIDTH(AW), .DEAD_ZONE(64), .TILT_SHIFT(7),
        .BASE_PERIOD(256), .MIN_GAP(16), .CNT_WIDTH(32)
    ) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .accel_valid(accel_valid),
        .accel_x(accel_x), .accel_y(accel_y),
        .movement(movement), .tilt_dir(tilt_dir), .tilt_level(tilt_level)
    );

    tilt_move_gen #(
        .ACCEL_WIDTH(AW), .DEAD_ZONE(64), .TILT_SHIFT(7),
        .BASE_PERIOD(64), .MIN_GAP(16), .CNT_WIDTH(32)
    ) u_dut_fast (
        .clk(clk), .reset(reset), .enable(enable), .accel_valid(accel_valid),
        .accel_x(accel_x), .accel_y(accel_y),
        .movement(fast_movement), .tilt_dir(fast_dir), .tilt_level(fast_level)
    );

    // Every pulse must be one-hot and never follow another pulse directly.
    always @(negedge clk) begin
        if (reset) begin
            if (movement != 0 && (!$onehot(movement) || prev_m != 0)) mon_bad <= mon_bad + 1;
            if (fast_movement != 0 && (!$onehot(fast_movement) || prev_f != 0))
                mon_bad <= mon_bad + 1;
        end
        prev_m <= movement;
        prev_f <= fast_movement;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic strobe(input int x, input int y);
        accel_x     = x[AW-1:0];
        accel_y     = y[AW-1:0];
        accel_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        accel_valid = 1'b0;
    endtask

    // Counts edges until the selected instance shows a pulse; -1 on timeout.
    task automatic wait_pulse(input bit fast, input int max_cyc, output int cyc, output int mv);
        cyc = -1;
        mv  = 0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((fast ? fast_movement : movement) != 0) begin
                cyc = i;
                mv  = int'(fast ? fast_movement : movement);
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        int c, m, cnt;

        vecs[0]  = '{64, -60, 0, 0};
        vecs[1]  = '{65, 0, 8, 0};
        vecs[2]  = '{100, 0, 8, 0};
        vecs[3]  = '{-300, 300, 4, 1};
        vecs[4]  = '{-300, 400, 2, 2};
        vecs[5]  = '{0, -2048, 1, 3};
        vecs[6]  = '{500, 0, 8, 3};
        vecs[7]  = '{-192, 0, 4, 0};
        vecs[8]  = '{2047, -2047, 8, 3};
        vecs[9]  = '{-2048, 2047, 4, 3};
        vecs[10] = '{0, -65, 1, 0};
        vecs[11] = '{-193, 64, 4, 1};

        enable = 1'b1;
        #1;
        chk("reset_movement", int'(movement), 0);
        chk("reset_dir", int'(tilt_dir), 0);
        chk("reset_level", int'(tilt_level), 0);
        tick(2);
        reset = 1'b1;

        // Dead-zone edge: no motion at all
        strobe(64, -60);
        tick(1);
        chk("t1_dir", int'(tilt_dir), 0);
        cnt = 0;
        repeat (2000) begin
            tick(1);
            if (movement != 0) cnt++;
        end
        chk("t1_quiet", cnt, 0);

        foreach (vecs[i]) begin
            strobe(vecs[i].x, vecs[i].y);
            tick(1);
            chk($sformatf("vec%0d_dir", i), int'(tilt_dir), vecs[i].dir);
            chk($sformatf("vec%0d_level", i), int'(tilt_level), vecs[i].lvl);
        end

        // Level 0 RIGHT, then level 3 mid-run
        do_reset();
        strobe(100, 0);
        wait_pulse(0, 400, c, m);
        chk("t2_first_lat", c, 3);
        chk("t2_first_dir", m, 8);
        wait_pulse(0, 400, c, m);
        chk("t2_period256", c, 256);
        chk("t2_dir", m, 8);
        strobe(500, 0);
        wait_pulse(0, 400, c, m);
        chk("t2_lvl3_first", c, 31);
        wait_pulse(0, 400, c, m);
        chk("t2_period32", c, 32);
        chk("t2_lvl3_dir", m, 8);
        chk("t2_level", int'(tilt_level), 3);

        // Tie goes to X; then switch to DOWN honouring the gap
        strobe(-300, 300);
        wait_pulse(0, 400, c, m);
        chk("t3_left_lat", c, 15);
        chk("t3_left_dir", m, 4);
        chk("t3_left_level", int'(tilt_level), 1);
        wait_pulse(0, 400, c, m);
        chk("t3_period128", c, 128);
        strobe(-300, 400);
        wait_pulse(0, 400, c, m);
        chk("t3_gap", c + 1, 16);
        chk("t3_down_dir", m, 2);
        wait_pulse(0, 400, c, m);
        chk("t3_period64", c, 64);
        chk("t3_down_dir2", m, 2);

        // Most-negative sample
        strobe(0, -2048);
        wait_pulse(0, 400, c, m);
        chk("t4_up_lat", c, 15);
        chk("t4_up_dir", m, 1);
        chk("t4_level", int'(tilt_level), 3);
        tick(1);
        chk("t4_width", int'(movement), 0);
        wait_pulse(0, 400, c, m);
        chk("t4_period32", c, 31);
        chk("t4_up_dir2", m, 1);

        // Period clamped to MIN_GAP; enable dropped right in the due cycle
        wait_pulse(1, 400, c, m);
        chk("t5_fast_dir", m, 1);
        wait_pulse(1, 400, c, m);
        chk("t5_period16", c, 16);
        tick(15);
        enable = 1'b0;
        tick(1);
        chk("t5_drop_fast", int'(fast_movement), 0);
        chk("t5_drop_main", int'(movement), 0);
        cnt = 0;
        repeat (40) begin
            tick(1);
            if (movement != 0 || fast_movement != 0) cnt++;
        end
        chk("t5_disabled_quiet", cnt, 0);
        enable = 1'b1;
        wait_pulse(1, 400, c, m);
        chk("t5_reenable_lat", c, 2);
        chk("t5_reenable_dir", m, 1);
        chk("t5_reenable_main", int'(movement), 1);
        wait_pulse(1, 400, c, m);
        chk("t5_period16_again", c, 16);

        // Async reset landing on a pulse
        wait_pulse(0, 400, c, m);
        chk("t6_pre_dir", m, 1);
        reset = 1'b0;
        #1;
        chk("t6_async_movement", int'(movement), 0);
        chk("t6_async_dir", int'(tilt_dir), 0);
        chk("t6_async_level", int'(tilt_level), 0);
        tick(2);
        reset = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick(1);
            if (movement != 0 || fast_movement != 0) cnt++;
        end
        chk("t6_quiet_after_reset", cnt, 0);
        strobe(0, -2048);
        wait_pulse(0, 400, c, m);
        chk("t6_first_lat", c, 3);
        chk("t6_first_dir", m, 1);

        tick(1);
        chk("onehot_monitor", mon_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
